xcorr_pair_sched: RTL and testbench

- Sequences the shared cross-correlator across microphone pairs: reference mic 0 against mic 1..NUM_MICS-1.
- Per batch, in order:
  - request one capture of all mic buffers;
  - for each pair, steer the buffer read muxes, restart the correlator and wait for it to finish;
  - scan the correlator result memory for the peak and report the signed lag.
- Sits between the capture front-end, the correlator (xcorr) and the beam-steering logic.

---
 rtl/xcorr_pkg.sv | 24 ++
 rtl/xcorr_pair_sched_if.sv | 42 ++++
 rtl/xcorr_pair_sched_peak_tracker.sv | 38 +++
 rtl/xcorr_pair_sched.sv | 170 +++++++++++++++++
 tb/tb_xcorr_pair_sched.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/xcorr_pkg.sv
// Shared definitions for the cross-correlator pair scheduler.
//   sched_state_t : scheduler FSM states
//   XC_ARM_CYCLES : cycles spent ignoring the correlator's stale standby after restart
//   lag_width()   : signed lag width for a given result address width
package xcorr_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        XC_START,
        XC_ARM,
        XC_WAIT,
        SCAN,
        REPORT
    } sched_state_t;

    localparam int unsigned XC_ARM_CYCLES = 1;

    // Lag spans -2**addr_width .. 2**addr_width-2, so one extra sign bit.
    function automatic int lag_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/xcorr_pair_sched_if.sv
// Bundle of scheduler-side signals towards the capture front-end, the
// correlator, its result memory and the beam-steering consumer.
//   master : scheduler view (drives cap_req, mic_b_sel, xc_rst, rd_addr and results)
//   slave  : environment view (drives start, cap_done, xc_standby, rd_data)
interface xcorr_pair_sched_if #(
    parameter int NUM_MICS       = 4,
    parameter int OUT_ADDR_WIDTH = 8,
    parameter int SUM_WIDTH      = 24
);
    import xcorr_pkg::*;

    localparam int MIC_W = $clog2(NUM_MICS);
    localparam int LAG_W = lag_width(OUT_ADDR_WIDTH);

    logic                         start;
    logic                         cap_req;
    logic                         cap_done;
    logic [MIC_W-1:0]             mic_b_sel;
    logic                         xc_rst;
    logic                         xc_standby;
    logic [OUT_ADDR_WIDTH-1:0]    rd_addr;
    logic signed [SUM_WIDTH-1:0]  rd_data;
    logic                         lag_valid;
    logic [MIC_W-1:0]             lag_pair;
    logic signed [LAG_W-1:0]      lag;
    logic signed [SUM_WIDTH-1:0]  peak;
    logic                         busy;
    logic                         err_timeout;

    modport master (
        input  start, cap_done, xc_standby, rd_data,
        output cap_req, mic_b_sel, xc_rst, rd_addr,
               lag_valid, lag_pair, lag, peak, busy, err_timeout
    );

    modport slave (
        output start, cap_done, xc_standby, rd_data,
        input  cap_req, mic_b_sel, xc_rst, rd_addr,
               lag_valid, lag_pair, lag, peak, busy, err_timeout
    );

endinterface

// File: rtl/xcorr_pair_sched_peak_tracker.sv
// Running signed maximum over a stream of (value, index) samples.
//   clk, rst  : clock, synchronous active-high reset
//   clear     : forget the current maximum; next valid sample loads unconditionally
//   valid     : value/index present this cycle
//   value     : signed sample
//   index     : sample position
//   max_value : largest sample seen since clear
//   max_index : index of that sample (lowest index on ties)
module peak_tracker #(
    parameter int VALUE_WIDTH = 24,
    parameter int INDEX_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic                          valid,
    input  logic signed [VALUE_WIDTH-1:0] value,
    input  logic [INDEX_WIDTH-1:0]        index,
    output logic signed [VALUE_WIDTH-1:0] max_value,
    output logic [INDEX_WIDTH-1:0]        max_index
);

    logic loaded;

    // Strictly-greater compare keeps the earliest index when values tie.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            loaded    <= 1'b0;
            max_value <= '0;
            max_index <= '0;
        end else if (valid && (!loaded || value > max_value)) begin
            loaded    <= 1'b1;
            max_value <= value;
            max_index <= index;
        end
    end

endmodule

// File: rtl/xcorr_pair_sched.sv
// Runs the shared cross-correlator over mic pairs (0,1) .. (0,NUM_MICS-1):
// one capture per batch, then per pair restart the correlator, wait for
// standby, scan its result memory for the peak and report the signed lag.
//   clk, rst : clock, synchronous active-high reset
//   bus      : master side of xcorr_pair_sched_if
//     start/cap_req/cap_done    : batch start and capture handshake
//     mic_b_sel                 : b-buffer mic (a-buffer is mic 0)
//     xc_rst/xc_standby         : correlator restart and completion
//     rd_addr/rd_data           : result memory scan, 1-cycle read latency
//     lag_valid/lag_pair/lag/peak : per-pair result, held until next report
//     busy/err_timeout          : status; err_timeout sticky until rst or next start
module xcorr_pair_sched #(
    parameter int NUM_MICS       = 4,
    parameter int OUT_ADDR_WIDTH = 8,
    parameter int SUM_WIDTH      = 24,
    parameter int TIMEOUT_CYCLES = 131072
) (
    input  logic              clk,
    input  logic              rst,
    xcorr_pair_sched_if.master bus
);
    import xcorr_pkg::*;

    localparam int MIC_W  = $clog2(NUM_MICS);
    localparam int LAG_W  = lag_width(OUT_ADDR_WIDTH);
    localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SCAN_W = OUT_ADDR_WIDTH + 1;
    localparam int DEPTH  = 2 ** OUT_ADDR_WIDTH;

    localparam logic [MIC_W-1:0]  FIRST_MIC = MIC_W'(1);
    localparam logic [MIC_W-1:0]  LAST_MIC  = MIC_W'(NUM_MICS - 1);
    localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  ARM_LAST  = CNT_W'(XC_ARM_CYCLES - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(DEPTH);

    sched_state_t                state, state_nxt;
    logic [CNT_W-1:0]            cnt, cnt_nxt;
    logic [SCAN_W-1:0]           scan_cnt, scan_nxt;
    logic [MIC_W-1:0]            mic_sel, mic_nxt;
    logic                        err, err_nxt;

    logic signed [LAG_W-1:0]     lag_q;
    logic signed [SUM_WIDTH-1:0] peak_q;
    logic [MIC_W-1:0]            pair_q;

    logic                        pk_valid;
    logic [OUT_ADDR_WIDTH-1:0]   pk_index;
    logic signed [SUM_WIDTH-1:0] pk_max;
    logic [OUT_ADDR_WIDTH-1:0]   pk_idx;
    logic signed [LAG_W-1:0]     lag_live;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            scan_cnt <= '0;
            mic_sel  <= FIRST_MIC;
            err      <= 1'b0;
            lag_q    <= '0;
            peak_q   <= '0;
            pair_q   <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            scan_cnt <= scan_nxt;
            mic_sel  <= mic_nxt;
            err      <= err_nxt;
            if (state == REPORT) begin
                lag_q  <= lag_live;
                peak_q <= pk_max;
                pair_q <= mic_sel;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        scan_nxt  = '0;
        mic_nxt   = mic_sel;
        err_nxt   = err;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    err_nxt   = 1'b0;
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                if (bus.cap_done) begin
                    mic_nxt   = FIRST_MIC;
                    state_nxt = XC_START;
                end
            end
            XC_START: begin
                cnt_nxt   = '0;
                state_nxt = XC_ARM;
            end
            // Correlator still shows the previous run's standby here.
            XC_ARM: begin
                if (cnt == ARM_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = XC_WAIT;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            XC_WAIT: begin
                if (bus.xc_standby) begin
                    state_nxt = SCAN;
                end else if (cnt == TO_LAST) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            // One extra cycle past the last address for the final read to land.
            SCAN: begin
                if (scan_cnt == SCAN_LAST) begin
                    state_nxt = REPORT;
                end else begin
                    scan_nxt = scan_cnt + SCAN_W'(1);
                end
            end
            REPORT: begin
                if (mic_sel < LAST_MIC) begin
                    mic_nxt   = mic_sel + MIC_W'(1);
                    state_nxt = XC_START;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Data on rd_data belongs to the address issued one cycle earlier.
    assign pk_valid = (state == SCAN) && (scan_cnt != '0);
    assign pk_index = OUT_ADDR_WIDTH'(scan_cnt - SCAN_W'(1));

    peak_tracker #(
        .VALUE_WIDTH (SUM_WIDTH),
        .INDEX_WIDTH (OUT_ADDR_WIDTH)
    ) u_peak (
        .clk       (clk),
        .rst       (rst),
        .clear     (state == XC_START),
        .valid     (pk_valid),
        .value     (bus.rd_data),
        .index     (pk_index),
        .max_value (pk_max),
        .max_index (pk_idx)
    );

    // lag = 2*idx - DEPTH, computed modulo 2**LAG_W.
    assign lag_live = LAG_W'({pk_idx, 1'b0}) - LAG_W'(DEPTH);

    assign bus.cap_req     = (state == CAPTURE);
    assign bus.xc_rst      = (state == XC_START);
    assign bus.busy        = (state != IDLE);
    assign bus.lag_valid   = (state == REPORT);
    assign bus.rd_addr     = (state == SCAN) ? scan_cnt[OUT_ADDR_WIDTH-1:0] : '0;
    assign bus.mic_b_sel   = mic_sel;
    assign bus.err_timeout = err;
    assign bus.lag         = (state == REPORT) ? lag_live : lag_q;
    assign bus.peak        = (state == REPORT) ? pk_max   : peak_q;
    assign bus.lag_pair    = (state == REPORT) ? mic_sel  : pair_q;

endmodule

// File: tb/tb_xcorr_pair_sched.sv
// Directed bench for xcorr_pair_sched: table of result-memory patterns with
// expected lag/peak, plus sequences for reset mid-scan, start/rst collision
// and correlator timeout (second instance with a short timeout).
module tb_xcorr_pair_sched;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    xcorr_pair_sched_if #(.NUM_MICS(4), .OUT_ADDR_WIDTH(8), .SUM_WIDTH(24)) ifc ();
    xcorr_pair_sched_if #(.NUM_MICS(4), .OUT_ADDR_WIDTH(8), .SUM_WIDTH(24)) ifc_t ();

    xcorr_pair_sched #(
        .NUM_MICS(4), .OUT_ADDR_WIDTH(8), .SUM_WIDTH(24), .TIMEOUT_CYCLES(131072)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.master)
    );

    xcorr_pair_sched #(
        .NUM_MICS(4), .OUT_ADDR_WIDTH(8), .SUM_WIDTH(24), .TIMEOUT_CYCLES(64)
    ) dut_to (
        .clk (clk),
        .rst (rst),
        .bus (ifc_t.master)
    );

    // Correlator/result-memory model for the main instance.
    logic signed [23:0] mem [256];
    int sb_cnt;
    int sb_delay;

    always @(posedge clk) begin
        if (rst)              sb_cnt <= 0;
        else if (ifc.xc_rst)  sb_cnt <= 1;
        else if (sb_cnt != 0 && sb_cnt < 1000000) sb_cnt <= sb_cnt + 1;
    end
    // Standby stays stale-high the cycle after restart, then low until the delay expires.
    assign ifc.xc_standby = (sb_cnt <= 1) || (sb_cnt > sb_delay);
    always @(posedge clk) ifc.rd_data <= mem[ifc.rd_addr];

    assign ifc_t.xc_standby = 1'b0;
    assign ifc_t.rd_data    = '0;

    typedef struct {
        int idx_a;
        int idx_b;
        int val;
        int base;
        int delay;
        bit inject;
        int exp_lag;
        int exp_peak;
    } vec_t;

    localparam int NV = 5;
    vec_t vecs [NV];

    int n_tests = 0;
    int n_fail  = 0;
    int npulse;
    int early;
    int pulse_pair [8];
    int pulse_lag  [8];
    int pulse_peak [8];

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic load_mem(input int v);
        for (int i = 0; i < 256; i++) mem[i] = 24'(vecs[v].base);
        mem[vecs[v].idx_a] = 24'(vecs[v].val);
        mem[vecs[v].idx_b] = 24'(vecs[v].val);
        sb_delay = vecs[v].delay;
    endtask

    task automatic run_batch(input bit inject, input bit do_rst);
        int cyc;
        int quiet;
        bit done;
        bit rst_hit;
        npulse  = 0;
        early   = 0;
        done    = 1'b0;
        rst_hit = 1'b0;
        ifc.start = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        cyc = 0;
        while (!ifc.cap_req && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("cap_req_seen", ifc.cap_req, 1);
        repeat (5) @(negedge clk);
        ifc.cap_done = 1'b1;
        @(negedge clk);
        ifc.cap_done = 1'b0;
        cyc = 0;
        while (!done && cyc < 5000) begin
            ifc.start = 1'b0;
            if (ifc.lag_valid && npulse < 8) begin
                pulse_pair[npulse] = int'(ifc.lag_pair);
                pulse_lag[npulse]  = int'(ifc.lag);
                pulse_peak[npulse] = int'(ifc.peak);
                npulse++;
                if (inject) ifc.start = 1'b1;
            end
            if (inject && sb_cnt == 10) ifc.start = 1'b1;
            if (ifc.rd_addr != 0 && !ifc.xc_standby) early++;
            if (ifc.rd_addr != 0 && (ifc.cap_req || ifc.xc_rst || ifc.lag_valid)) early++;
            if (do_rst && npulse == 1 && ifc.rd_addr == 8'd100) begin
                rst_hit = 1'b1;
                chk("rst_pair_sel", ifc.mic_b_sel, 2);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("rst_busy", ifc.busy, 0);
                chk("rst_lag_valid", ifc.lag_valid, 0);
                chk("rst_rd_addr", ifc.rd_addr, 0);
                chk("rst_mic_sel", ifc.mic_b_sel, 1);
                quiet = 0;
                repeat (300) begin
                    @(negedge clk);
                    if (ifc.lag_valid || ifc.busy) quiet++;
                end
                chk("rst_quiet", quiet, 0);
                done = 1'b1;
            end else if (!ifc.busy) begin
                done = 1'b1;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        ifc.start = 1'b0;
        chk("batch_done", done, 1);
        if (do_rst) chk("rst_hit", rst_hit, 1);
    endtask

    task automatic check_batch(input int v);
        chk($sformatf("v%0d_busy", v), ifc.busy, 0);
        chk($sformatf("v%0d_pulses", v), npulse, 3);
        chk($sformatf("v%0d_early_scan", v), early, 0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("v%0d_pair%0d", v, i), pulse_pair[i], i + 1);
            chk($sformatf("v%0d_lag%0d", v, i), pulse_lag[i], vecs[v].exp_lag);
            chk($sformatf("v%0d_peak%0d", v, i), pulse_peak[i], vecs[v].exp_peak);
        end
        chk($sformatf("v%0d_lag_hold", v), longint'(ifc.lag), vecs[v].exp_lag);
        chk($sformatf("v%0d_peak_hold", v), longint'(ifc.peak), vecs[v].exp_peak);
        chk($sformatf("v%0d_pair_hold", v), ifc.lag_pair, 3);
    endtask

    task automatic timeout_test();
        bit seen_lv;
        ifc_t.start = 1'b1;
        @(negedge clk);
        ifc_t.start = 1'b0;
        chk("to_cap_req", ifc_t.cap_req, 1);
        ifc_t.cap_done = 1'b1;
        @(negedge clk);
        ifc_t.cap_done = 1'b0;
        chk("to_xc_rst", ifc_t.xc_rst, 1);
        seen_lv = 1'b0;
        // Negedge k=1 is XC_ARM, k=2 is the first XC_WAIT cycle.
        for (int k = 1; k <= 66; k++) begin
            @(negedge clk);
            if (ifc_t.lag_valid) seen_lv = 1'b1;
            if (k == 65) begin
                chk("to_err_early", ifc_t.err_timeout, 0);
                chk("to_busy_early", ifc_t.busy, 1);
            end
        end
        chk("to_err_set", ifc_t.err_timeout, 1);
        chk("to_idle", ifc_t.busy, 0);
        chk("to_no_lag_valid", seen_lv, 0);
        repeat (5) @(negedge clk);
        chk("to_err_sticky", ifc_t.err_timeout, 1);
        ifc_t.start = 1'b1;
        @(negedge clk);
        ifc_t.start = 1'b0;
        chk("to_err_cleared", ifc_t.err_timeout, 0);
        chk("to_restart_busy", ifc_t.busy, 1);
    endtask

    initial begin
        rst            = 1'b1;
        ifc.start      = 1'b0;
        ifc.cap_done   = 1'b0;
        ifc_t.start    = 1'b0;
        ifc_t.cap_done = 1'b0;
        sb_delay       = 300;
        for (int i = 0; i < 256; i++) mem[i] = '0;

        //            idx_a idx_b val       base      delay inj lag   peak
        vecs[0] = '{130, 130, 1000,     0,        300,  0,   4,   1000};
        vecs[1] = '{10,  200, -5,       -100,     300,  1,  -236, -5};
        vecs[2] = '{0,   0,   7,        -1,       50,   0,  -256, 7};
        vecs[3] = '{255, 255, 8388607,  0,        60,   0,   254, 8388607};
        vecs[4] = '{128, 128, -8388608, -8388608, 40,   0,  -256, -8388608};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_cap_req", ifc.cap_req, 0);
        chk("rst_xc_rst", ifc.xc_rst, 0);
        chk("rst_lag_valid0", ifc.lag_valid, 0);
        chk("rst_busy0", ifc.busy, 0);
        chk("rst_err", ifc.err_timeout, 0);
        chk("rst_rd_addr0", ifc.rd_addr, 0);
        chk("rst_lag", longint'(ifc.lag), 0);
        chk("rst_peak", longint'(ifc.peak), 0);
        chk("rst_lag_pair", ifc.lag_pair, 0);
        chk("rst_mic_b_sel", ifc.mic_b_sel, 1);

        ifc.cap_done = 1'b1;
        @(negedge clk);
        ifc.cap_done = 1'b0;
        @(negedge clk);
        chk("cap_done_idle_busy", ifc.busy, 0);
        chk("cap_done_idle_req", ifc.cap_req, 0);

        for (int v = 0; v < NV; v++) begin
            load_mem(v);
            run_batch(vecs[v].inject, 1'b0);
            check_batch(v);
            @(negedge clk);
        end

        load_mem(0);
        run_batch(1'b0, 1'b1);

        rst = 1'b1;
        ifc.start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ifc.start = 1'b0;
        chk("start_rst_busy", ifc.busy, 0);
        @(negedge clk);
        chk("start_rst_busy2", ifc.busy, 0);
        chk("start_rst_cap_req", ifc.cap_req, 0);

        run_batch(1'b0, 1'b0);
        check_batch(0);

        timeout_test();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
